mfsk_tx: RTL and testbench
==========================

MFSK_TX -- requirements
Module: mfsk_tx

Interface
REQ-001 Parameter DATA_W, default 16, input word width in bits; SHALL be a multiple of BITS_PER_SYM.
REQ-002 Parameter BITS_PER_SYM, default 1, bits per symbol (1..3), tone count M = 2^BITS_PER_SYM.
REQ-003 Parameter SPS, default 50, clock cycles per symbol, minimum 2.
REQ-004 Parameter PHASE_W, default 32, phase accumulator width.
REQ-005 Parameter LUT_AW, default 10, sine table address width (top LUT_AW phase bits).
REQ-006 Parameter OUT_W, default 16, signed sample width.
REQ-007 Parameter F0_FTW, default 85899346, tuning word of tone 0 (1 MHz at 50 MHz clock).
REQ-008 Parameter FTW_STEP, default 85899346, tuning word increment per tone index.
REQ-009 sys_clk  input  1  single clock; all logic on rising edge.
REQ-010 sys_rst  input  1  synchronous reset, active-high.
REQ-011 data_in  input  DATA_W  word to transmit, sampled on accept.
REQ-012 data_valid  input  1  data_in valid.
REQ-013 data_ready  output  1  block can accept a word this cycle.
REQ-014 tx  output  OUT_W  signed two's-complement sine sample.
REQ-015 tx_valid  output  1  tx holds a modulated sample.
REQ-016 sym_strobe  output  1  one-cycle pulse aligned with first tx sample of each symbol.
REQ-017 busy  output  1  high while a word is being transmitted.
REQ-018 done  output  1  one-cycle pulse aligned with last tx sample of a word.

Function
REQ-019 Accept SHALL occur on a rising edge with data_valid and data_ready both high; data_in is latched into a shift register at that edge.
REQ-020 FSM SHALL have states IDLE and SEND; IDLE->SEND on accept; SEND->IDLE after last sample of last symbol with no accept; SEND->SEND on accept in that same cycle.
REQ-021 data_ready SHALL be high in IDLE and in the final SEND cycle of a word; low otherwise.
REQ-022 Symbols SHALL be sent MSB-first, NSYM = DATA_W/BITS_PER_SYM symbols per word; symbol value m selects FTW = F0_FTW + m*FTW_STEP, computed modulo 2^PHASE_W.
REQ-023 Each symbol SHALL last exactly SPS cycles; sample counter wraps SPS-1 -> 0 and advances symbol index.
REQ-024 Phase accumulator SHALL add the current FTW every SEND cycle and hold in IDLE; overflow wraps modulo 2^PHASE_W.
REQ-025 Sample SHALL equal round((2^(OUT_W-1)-1)*sin(2*pi*a/2^LUT_AW)), a = phase[PHASE_W-1 -: LUT_AW].
REQ-026 tx_valid SHALL rise exactly 2 cycles after the accept edge and remain high for NSYM*SPS consecutive cycles; back-to-back words SHALL produce gap-free tx_valid.
REQ-027 tx SHALL be 0 whenever tx_valid is low.
REQ-028 busy SHALL equal (state == SEND); sym_strobe and done are aligned to tx_valid timing.
REQ-029 data_valid while data_ready is low SHALL be ignored; data_in changes during SEND SHALL not affect the word in flight.

Reset
REQ-030 sys_rst SHALL force IDLE, clear phase, counters and shift register; tx=0, tx_valid=0, sym_strobe=0, done=0, busy=0, data_ready=1 on the following cycle.
REQ-031 Reset asserted mid-word SHALL abort the word with no done pulse; reset overrides a simultaneous accept.

Configuration
REQ-032 Macro MFSK_TX_PHASE_RESET_EN defined: phase accumulator SHALL clear to 0 at the first cycle of every symbol (phase-coherent, every symbol starts at sample 0).
REQ-033 Macro MFSK_TX_PHASE_RESET_EN undefined: phase SHALL be continuous across symbols and words (CPFSK), cleared only by reset.

Verification
REQ-034 Defaults, data_in=16'hA5F0 accepted -> tx_valid high 800 cycles from accept+2; tone per 50-cycle symbol: 2,1,2,1,1,2,1,2,2,2,2,2,1,1,1,1 MHz (1 cycle/2 cycles per 50); done on cycle 800.
REQ-035 Two words, second data_valid held high -> second accepted in final SEND cycle of first; tx_valid continuous 1600 cycles; exactly two done pulses.
REQ-036 BITS_PER_SYM=2, DATA_W=8, data_in=8'b00_01_10_11 -> 4 symbols of 1,2,3,4 MHz, 200 valid cycles, 4 sym_strobe pulses.
REQ-037 sys_rst pulsed at cycle 300 of a word -> next cycle tx=0, tx_valid=0, busy=0, data_ready=1; no done pulse.
REQ-038 Symbol boundary sample check: without macro, |tx[n]-tx[n-1]| bounded by max slope at the tone switch; with MFSK_TX_PHASE_RESET_EN, first sample of each symbol equals 0.
REQ-039 data_valid toggled and data_in changed during SEND -> no accept, transmitted bits match the originally latched word.

Source files
------------

// File: rtl/mfsk_tx_if.sv
// mfsk_tx_if: word handshake and modulated sample bundle for mfsk_tx.
// master: data_in/data_valid out; slave: data_ready, tx, tx_valid, sym_strobe, busy, done out.
interface mfsk_tx_if #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 16
);
  logic [DATA_W-1:0]       data_in;
  logic                    data_valid;
  logic                    data_ready;
  logic signed [OUT_W-1:0] tx;
  logic                    tx_valid;
  logic                    sym_strobe;
  logic                    busy;
  logic                    done;

  modport master (
    output data_in, data_valid,
    input  data_ready, tx, tx_valid, sym_strobe, busy, done
  );

  modport slave (
    input  data_in, data_valid,
    output data_ready, tx, tx_valid, sym_strobe, busy, done
  );
endinterface

// File: rtl/mfsk_tx.sv
// mfsk_tx: M-ary FSK transmitter, DDS phase accumulator plus sine LUT, MSB-first symbols.
// Ports: sys_clk, sys_rst (sync, active-high), bus (mfsk_tx_if.slave).
// Option: MFSK_TX_PHASE_RESET_EN clears phase at each symbol start (default: continuous phase).
module mfsk_tx #(
  parameter int DATA_W       = 16,
  parameter int BITS_PER_SYM = 1,
  parameter int SPS          = 50,
  parameter int PHASE_W      = 32,
  parameter int LUT_AW       = 10,
  parameter int OUT_W        = 16,
  parameter int F0_FTW       = 85899346,
  parameter int FTW_STEP     = 85899346
) (
  input logic         sys_clk,
  input logic         sys_rst,
  mfsk_tx_if.slave    bus
);
  localparam int NSYM = DATA_W / BITS_PER_SYM;
  localparam int CW   = $clog2(SPS);
  localparam int SW   = (NSYM > 1) ? $clog2(NSYM) : 1;
  localparam int AMP  = 2 ** (OUT_W - 1) - 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t state_q, state_d;

  logic [CW-1:0]           cnt;
  logic [SW-1:0]           sym;
  logic [DATA_W-1:0]       sr;
  logic [PHASE_W-1:0]      phase;
  logic [PHASE_W-1:0]      phase_eff;
  logic [PHASE_W-1:0]      ftw;
  logic [BITS_PER_SYM-1:0] sym_val;
  logic                    cnt_wrap;
  logic                    last;
  logic                    accept;
  logic                    send;

  logic                    s1_valid;
  logic                    s1_strobe;
  logic                    s1_done;
  logic [LUT_AW-1:0]       s1_addr;

  logic signed [OUT_W-1:0] lut [2**LUT_AW];

  // Quarter-free full-cycle table, rounded to nearest at elaboration.
  for (genvar i = 0; i < 2**LUT_AW; i++) begin : g_lut
    localparam real ANG = 6.283185307179586 * i / (2.0 ** LUT_AW);
    localparam real X   = AMP * $sin(ANG);
    localparam int  V   = (X >= 0.0) ? $rtoi(X + 0.5) : $rtoi(X - 0.5);
    assign lut[i] = OUT_W'(V);
  end

  assign send     = (state_q == SEND);
  assign cnt_wrap = (cnt == CW'(SPS - 1));
  assign last     = send && cnt_wrap && (sym == SW'(NSYM - 1));

  assign bus.data_ready = (state_q == IDLE) || last;
  assign bus.busy       = send;
  assign accept         = bus.data_valid && bus.data_ready;

  assign sym_val = sr[DATA_W-1 -: BITS_PER_SYM];
  assign ftw = PHASE_W'(F0_FTW)
             + PHASE_W'(sym_val) * PHASE_W'(FTW_STEP);

`ifdef MFSK_TX_PHASE_RESET_EN
  assign phase_eff = (cnt == '0) ? '0 : phase;
`else
  assign phase_eff = phase;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = SEND;
      SEND:    if (last && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q        <= IDLE;
      cnt            <= '0;
      sym            <= '0;
      sr             <= '0;
      phase          <= '0;
      s1_valid       <= 1'b0;
      s1_strobe      <= 1'b0;
      s1_done        <= 1'b0;
      s1_addr        <= '0;
      bus.tx         <= '0;
      bus.tx_valid   <= 1'b0;
      bus.sym_strobe <= 1'b0;
      bus.done       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        sr  <= bus.data_in;
        cnt <= '0;
        sym <= '0;
      end else if (send) begin
        if (cnt_wrap) begin
          cnt <= '0;
          sym <= last ? '0 : sym + SW'(1);
          sr  <= sr << BITS_PER_SYM;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
      if (send) phase <= phase_eff + ftw;
      // Stage 1: address; stage 2: LUT sample.
      s1_valid       <= send;
      s1_strobe      <= send && (cnt == '0);
      s1_done        <= last;
      s1_addr        <= phase_eff[PHASE_W-1 -: LUT_AW];
      bus.tx_valid   <= s1_valid;
      bus.tx         <= s1_valid ? lut[s1_addr] : '0;
      bus.sym_strobe <= s1_valid && s1_strobe;
      bus.done       <= s1_valid && s1_done;
    end
  end
endmodule

// File: tb/tb_mfsk_tx.sv
// tb_mfsk_tx: randomized scoreboard bench for mfsk_tx.
// Drives words on two instances (defaults, and 2 bits/symbol 8-bit words).
module tb_mfsk_tx;
  localparam int SPS  = 50;
  localparam int N1   = 16 * SPS;
  localparam longint F0   = 85899346;
  localparam longint STEP = 85899346;
  localparam longint MASK = 64'hFFFF_FFFF;
  localparam real    AMP  = 32767.0;

  typedef struct {
    int cyc;
    int smp;
    bit stb;
    bit dn;
  } exp_t;

  logic clk = 1'b0;
  logic sys_rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   free_edge = 0;
  int   done_cnt0 = 0;
  int   done_cnt1 = 0;
  int   stb_cnt1 = 0;
  longint mph [2];
  exp_t q0 [$];
  exp_t q1 [$];

  mfsk_tx_if #(.DATA_W(16), .OUT_W(16)) b1 ();
  mfsk_tx_if #(.DATA_W(8),  .OUT_W(16)) b2 ();

  mfsk_tx dut1 (.sys_clk(clk), .sys_rst(sys_rst), .bus(b1.slave));
  mfsk_tx #(.DATA_W(8), .BITS_PER_SYM(2)) dut2 (
    .sys_clk(clk), .sys_rst(sys_rst), .bus(b2.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int samp(input longint a);
    real x;
    x = AMP * $sin(6.283185307179586 * a / 1024.0);
    return (x >= 0.0) ? $rtoi(x + 0.5) : $rtoi(x - 0.5);
  endfunction

  task automatic chk(input bit ok, input string msg);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s", msg);
    end
  endtask

  // Expected samples for a word accepted at edge ea: tone per symbol,
  // phase either continuous or restarting at every symbol.
  task automatic push(input int d, input logic [15:0] w,
                      input int bps, input int nsym, input int ea);
    longint ftw, a;
    int m, k;
    exp_t e;
    k = 0;
    for (int s = 0; s < nsym; s++) begin
      m = int'((w >> ((nsym - 1 - s) * bps)) & ((16'd1 << bps) - 1));
      ftw = (F0 + m * STEP) & MASK;
      for (int j = 0; j < SPS; j++) begin
`ifdef MFSK_TX_PHASE_RESET_EN
        a = (j * ftw) & MASK;
`else
        a = mph[d];
        mph[d] = (mph[d] + ftw) & MASK;
`endif
        e.cyc = ea + 2 + k;
        e.smp = samp(a >> 22);
        e.stb = (j == 0);
        e.dn  = (k == nsym * SPS - 1);
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
        k++;
      end
    end
  endtask

  task automatic mon(input int d, input logic v, input int txv,
                     input logic stb, input logic dn);
    exp_t e;
    int   sz;
    sz = (d == 0) ? q0.size() : q1.size();
    if (v) begin
      if (sz == 0) begin
        chk(0, $sformatf("extra_sample dut%0d cyc=%0d tx=%0d", d, cyc, txv));
      end else begin
        if (d == 0) e = q0.pop_front();
        else e = q1.pop_front();
        chk(e.cyc == cyc && e.smp == txv && e.stb == stb && e.dn == dn,
            $sformatf("sample dut%0d got cyc=%0d tx=%0d stb=%0b done=%0b want cyc=%0d tx=%0d stb=%0b done=%0b",
                      d, cyc, txv, stb, dn, e.cyc, e.smp, e.stb, e.dn));
      end
    end else begin
      chk(txv == 0 && !stb && !dn,
          $sformatf("idle_out dut%0d cyc=%0d got tx=%0d stb=%0b done=%0b want 0/0/0",
                    d, cyc, txv, stb, dn));
      if (sz != 0) begin
        if (d == 0) e = q0[0];
        else e = q1[0];
        if (e.cyc <= cyc) begin
          if (d == 0) void'(q0.pop_front());
          else void'(q1.pop_front());
          chk(0, $sformatf("missing_sample dut%0d got tx_valid=0 want sample at cyc=%0d", d, e.cyc));
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (!sys_rst) begin
      mon(0, b1.tx_valid, int'(b1.tx), b1.sym_strobe, b1.done);
      mon(1, b2.tx_valid, int'(b2.tx), b2.sym_strobe, b2.done);
      if (b1.done) done_cnt0++;
      if (b2.done) done_cnt1++;
      if (b2.sym_strobe) stb_cnt1++;
    end
  end

  // mode 0: valid low while busy; 1: valid held high; 2: random valid/data.
  task automatic send(input logic [15:0] w, input int mode, output int ea);
    ea = (cyc + 1 > free_edge) ? cyc + 1 : free_edge;
    while (cyc + 1 < ea) begin
      chk(b1.data_ready == 1'b0 && b1.busy == 1'b1,
          $sformatf("busy_wait cyc=%0d got ready=%0b busy=%0b want 0/1",
                    cyc, b1.data_ready, b1.busy));
      case (mode)
        1: begin b1.data_valid = 1'b1; b1.data_in = w; end
        2: begin
          b1.data_valid = 1'($urandom_range(0, 1));
          b1.data_in = 16'($urandom);
        end
        default: b1.data_valid = 1'b0;
      endcase
      @(posedge clk); #1;
    end
    chk(b1.data_ready == 1'b1,
        $sformatf("ready_at_accept cyc=%0d got %0b want 1", cyc, b1.data_ready));
    b1.data_valid = 1'b1;
    b1.data_in = w;
    push(0, w, 1, 16, ea);
    free_edge = ea + N1;
    @(posedge clk); #1;
    b1.data_valid = 1'b0;
    b1.data_in = 16'($urandom);
  endtask

  task automatic wait_idle();
    while (cyc < free_edge + 4) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int ea;
    int guard;
    mph[0] = 0;
    mph[1] = 0;
    sys_rst = 1'b1;
    b1.data_valid = 1'b0;
    b1.data_in = '0;
    b2.data_valid = 1'b0;
    b2.data_in = '0;
    repeat (3) @(posedge clk);
    #1 sys_rst = 1'b0;
    @(negedge clk);
    chk(b1.tx == 0 && !b1.tx_valid && !b1.busy && b1.data_ready && !b1.done,
        $sformatf("reset_state1 got tx=%0d v=%0b busy=%0b rdy=%0b done=%0b",
                  b1.tx, b1.tx_valid, b1.busy, b1.data_ready, b1.done));
    chk(b2.tx == 0 && !b2.tx_valid && !b2.busy && b2.data_ready,
        $sformatf("reset_state2 got tx=%0d v=%0b busy=%0b rdy=%0b",
                  b2.tx, b2.tx_valid, b2.busy, b2.data_ready));
    @(posedge clk); #1;

    send(16'hA5F0, 0, ea);
    wait_idle();
    send(16'($urandom), 0, ea);
    send(16'($urandom), 1, ea);
    wait_idle();
    send(16'($urandom), 2, ea);
    send(16'($urandom), 2, ea);
    wait_idle();

    send(16'($urandom), 0, ea);
    while (cyc < ea + 300) begin
      @(posedge clk); #1;
    end
    sys_rst = 1'b1;
    @(posedge clk); #1;
    sys_rst = 1'b0;
    q0.delete();
    q1.delete();
    mph[0] = 0;
    mph[1] = 0;
    free_edge = 0;
    @(negedge clk);
    chk(b1.tx == 0 && !b1.tx_valid && !b1.busy && b1.data_ready,
        $sformatf("mid_reset got tx=%0d v=%0b busy=%0b rdy=%0b want 0/0/0/1",
                  b1.tx, b1.tx_valid, b1.busy, b1.data_ready));
    @(posedge clk); #1;
    send(16'($urandom), 0, ea);
    wait_idle();

    chk(b2.data_ready == 1'b1,
        $sformatf("ready2 got %0b want 1", b2.data_ready));
    b2.data_valid = 1'b1;
    b2.data_in = 8'b00_01_10_11;
    push(1, 16'h001B, 2, 4, cyc + 1);
    @(posedge clk); #1;
    b2.data_valid = 1'b0;
    repeat (4 * SPS + 6) @(posedge clk);
    #1;

    guard = 0;
    while ((q0.size() != 0 || q1.size() != 0) && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    chk(q0.size() == 0 && q1.size() == 0,
        $sformatf("drain got q0=%0d q1=%0d want 0/0", q0.size(), q1.size()));
    chk(done_cnt0 == 6,
        $sformatf("done_count1 got %0d want 6", done_cnt0));
    chk(done_cnt1 == 1 && stb_cnt1 == 4,
        $sformatf("dut2_pulses got done=%0d stb=%0d want 1/4", done_cnt1, stb_cnt1));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
